uart_reg_master: RTL and testbench

- Register-access master that feeds the UART command port and consumes its read-back byte.
- Accepts host read/write requests into a small request FIFO and packs each one into a 16-bit UART command.
- Issues each command with a one-cycle cmd_vld pulse, waits for the UART to finish, collects read data with a timeout, and returns one response per request to the host.

---
 rtl/uart_reg_master.sv | 162 ++++++++++++++++
 tb/tb_uart_reg_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_master.sv
// Register-access master: queues host read/write requests, issues them one at a
// time as 16-bit UART commands and returns one response per request, in order.
module uart_reg_master #(
  parameter int CMD_WIDTH  = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [CMD_WIDTH-1:0]  cmd_out,
  output logic                  cmd_vld,
  input  logic                  cmd_rdy,
  input  logic                  read_rdy,
  input  logic [DATA_WIDTH-1:0] read_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_RD, RESP} state_t;

  state_t state_reg, state_next;

  logic [CMD_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  fifo_empty, push, pop;

  logic [CMD_WIDTH-1:0]  cmd_reg;
  logic                  seen_busy_reg, rd_hit_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic [TO_W-1:0]       to_cnt_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;
  logic                  cmd_is_wr, to_expired;

  assign fifo_empty = (count_reg == '0);
  assign req_rdy    = (count_reg != FULL_CNT);
  assign push       = req_vld && req_rdy;
  assign pop        = (state_reg == IDLE) && !fifo_empty;
  assign cmd_is_wr  = cmd_reg[CMD_WIDTH-1];
  assign to_expired = (to_cnt_reg == TO_LAST);

  assign cmd_out   = cmd_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // Storage carries no reset so it maps onto plain RAM; pointers and count do.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {req_wr, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!fifo_empty) state_next = ISSUE;
      ISSUE:     if (cmd_rdy) state_next = WAIT_DONE;
      WAIT_DONE: if (seen_busy_reg && cmd_rdy) state_next = cmd_is_wr ? RESP : WAIT_RD;
      WAIT_RD:   if (rd_hit_reg || read_rdy || to_expired) state_next = RESP;
      RESP:      if (rsp_rdy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_vld = 1'b0;
    rsp_vld = 1'b0;
    case (state_reg)
      ISSUE:   cmd_vld = cmd_rdy;
      RESP:    rsp_vld = 1'b1;
      default: ;
    endcase
  end

  // The UART may answer a read before it reports idle, so WAIT_DONE keeps the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg       <= '0;
      seen_busy_reg <= 1'b0;
      rd_hit_reg    <= 1'b0;
      rd_data_reg   <= '0;
      to_cnt_reg    <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) cmd_reg <= fifo_mem[rd_ptr_reg];
        end
        ISSUE: begin
          if (cmd_rdy) begin
            seen_busy_reg <= 1'b0;
            rd_hit_reg    <= 1'b0;
          end
        end
        WAIT_DONE: begin
          to_cnt_reg <= '0;
          if (!cmd_rdy) seen_busy_reg <= 1'b1;
          if (read_rdy) begin
            rd_hit_reg  <= 1'b1;
            rd_data_reg <= read_data;
          end
          if (seen_busy_reg && cmd_rdy && cmd_is_wr) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
          end
        end
        WAIT_RD: begin
          if (rd_hit_reg) begin
            rsp_rdata_reg <= rd_data_reg;
            rsp_err_reg   <= 1'b0;
          end else if (read_rdy) begin
            rsp_rdata_reg <= read_data;
            rsp_err_reg   <= 1'b0;
          end else if (to_expired) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: a small UART model answers commands, a
// collector records responses, and the main sequence checks hand-computed values.
`timescale 1ns/1ps
module tb_uart_reg_master;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [CW-1:0] cmd_out;
  logic          cmd_vld;
  logic          cmd_rdy = 1'b1;
  logic          read_rdy = 1'b0;
  logic [DW-1:0] read_data = '0;

  always #5 clk = ~clk;

  uart_reg_master #(
    .CMD_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .read_rdy(read_rdy), .read_data(read_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s got=0x%0h", tag, got);
    end else begin
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // UART model: goes busy after each cmd_vld, then optionally returns a byte.
  int           busy_cycles = 5;
  int           rd_delay    = 2;
  bit           no_read     = 1'b0;
  bit           early_rd    = 1'b0;
  logic [7:0]   reg_file [128];
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [15:0]  m_cmd   = '0;
  int           cmd_count = 0;
  logic [15:0]  cmd_log [$];

  always @(negedge clk) begin
    read_rdy = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      cmd_rdy = 1'b1;
    end else begin
      case (m_phase)
        0: if (cmd_vld) begin
          m_cmd = cmd_out;
          cmd_log.push_back(cmd_out);
          cmd_count++;
          m_cnt   = busy_cycles;
          m_phase = 1;
        end
        1: begin
          if (early_rd && !m_cmd[15] && m_cnt == 2) begin
            read_rdy  = 1'b1;
            read_data = reg_file[m_cmd[14:8]];
          end
          if (m_cnt > 0) begin
            cmd_rdy = 1'b0;
            m_cnt--;
          end else begin
            cmd_rdy = 1'b1;
            if (!m_cmd[15] && !no_read && !early_rd) begin
              m_cnt   = rd_delay;
              m_phase = 2;
            end else begin
              m_phase = 0;
            end
          end
        end
        default: begin
          if (m_cnt == 0) begin
            read_rdy  = 1'b1;
            read_data = reg_file[m_cmd[14:8]];
            m_phase   = 0;
          end else begin
            m_cnt--;
          end
        end
      endcase
    end
  end

  // Response collector: {err, rdata} per completed handshake.
  logic [8:0] rsp_q [$];
  always begin
    @(negedge clk);
    #2;
    if (!rst && rsp_vld && rsp_rdy) begin
      rsp_q.push_back({rsp_err, rsp_rdata});
      $display("rsp  err=%0d rdata=0x%02h", rsp_err, rsp_rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_req(input logic wr, input logic [6:0] addr, input logic [7:0] wdata,
                          output bit accepted, output int held);
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_vld = 1'b1;
    accepted = 1'b0;
    held = 0;
    while (!accepted && held < 300) begin
      if (req_rdy) accepted = 1'b1;
      else held++;
      step();
    end
    req_vld = 1'b0;
    if (!accepted) check("push_timeout", 0, 1);
    $display("push wr=%0d addr=0x%02h wdata=0x%02h held=%0d", wr, addr, wdata, held);
  endtask

  task automatic wait_cmd_vld(input string tag, output int n);
    n = 0;
    while (!cmd_vld && n < 300) begin step(); n++; end
    if (!cmd_vld) check({tag, "_cmd_vld_timeout"}, 0, 1);
  endtask

  task automatic wait_cmd_rdy(input string tag, output int n);
    n = 0;
    while (!cmd_rdy && n < 300) begin step(); n++; end
    if (!cmd_rdy) check({tag, "_cmd_rdy_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp_vld(input string tag, output int n);
    n = 0;
    while (!rsp_vld && n < 300) begin step(); n++; end
    if (!rsp_vld) check({tag, "_rsp_vld_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp_count(input string tag, input int k);
    int n = 0;
    while (rsp_q.size() < k && n < 500) begin step(); n++; end
    if (rsp_q.size() < k) check({tag, "_rsp_count_timeout"}, rsp_q.size(), k);
  endtask

  task automatic expect_rsp(input string tag, input logic [8:0] exp);
    if (rsp_q.size() == 0) check({tag, "_missing"}, 0, 1);
    else check(tag, rsp_q.pop_front(), exp);
  endtask

  task automatic expect_cmd(input string tag, input logic [15:0] exp);
    if (cmd_log.size() == 0) check({tag, "_missing"}, 0, 1);
    else check(tag, cmd_log.pop_front(), exp);
  endtask

  initial begin
    bit acc;
    int held;
    int n;
    int c0;
    bit stable;

    for (int i = 0; i < 128; i++) reg_file[i] = 8'h00;
    reg_file[7'h05] = 8'h3C;
    reg_file[7'h06] = 8'hD2;
    reg_file[7'h22] = 8'h99;
    reg_file[7'h10] = 8'h61;
    reg_file[7'h12] = 8'h62;
    reg_file[7'h14] = 8'h63;
    reg_file[7'h33] = 8'hC7;

    // Reset values: {rsp_vld, cmd_vld, req_rdy, rsp_err, rsp_rdata, cmd_out}
    step(); step();
    check("reset_outs_in_rst", {rsp_vld, cmd_vld, req_rdy, rsp_err, rsp_rdata, cmd_out}, 28'h2000000);
    rst = 1'b0;
    step(); step();
    check("reset_outs_after", {rsp_vld, cmd_vld, req_rdy, rsp_err, rsp_rdata, cmd_out}, 28'h2000000);

    // Write 0x12 <= 0xA5, UART busy for 50 cycles
    busy_cycles = 50;
    push_req(1'b1, 7'h12, 8'hA5, acc, held);
    wait_cmd_vld("t1", n);
    check("t1_cmd_latency", n, 1);
    check("t1_cmd_out", cmd_out, 16'h92A5);
    step();
    check("t1_cmd_vld_one_cycle", cmd_vld, 0);
    wait_cmd_rdy("t1", n);
    check("t1_rsp_before_rdy", rsp_vld, 0);
    step();
    check("t1_rsp_vld_rise", rsp_vld, 1);
    wait_rsp_count("t1", 1);
    expect_rsp("t1_rsp", 9'h000);
    expect_cmd("t1_cmd_log", 16'h92A5);

    // Read 0x05, byte arrives after cmd_rdy returns
    busy_cycles = 5; rd_delay = 3;
    push_req(1'b0, 7'h05, 8'h00, acc, held);
    wait_cmd_vld("t2", n);
    check("t2_cmd_out", cmd_out, 16'h0500);
    wait_rsp_count("t2", 1);
    expect_rsp("t2_rsp", 9'h03C);
    expect_cmd("t2_cmd_log", 16'h0500);

    // Read 0x06, byte arrives while UART still busy
    early_rd = 1'b1;
    push_req(1'b0, 7'h06, 8'h00, acc, held);
    wait_rsp_count("t2b", 1);
    expect_rsp("t2b_rsp", 9'h0D2);
    expect_cmd("t2b_cmd_log", 16'h0600);
    early_rd = 1'b0;

    // Read timeout: WAIT_RD entered at the edge after cmd_rdy is seen high,
    // rsp_vld appears 20 edges later, i.e. 21 sample points from here.
    no_read = 1'b1; busy_cycles = 4;
    push_req(1'b0, 7'h22, 8'h00, acc, held);
    wait_cmd_vld("t3", n);
    step();
    wait_cmd_rdy("t3", n);
    wait_rsp_vld("t3", n);
    check("t3_timeout_latency", n, 21);
    wait_rsp_count("t3", 1);
    expect_rsp("t3_rsp", 9'h100);
    expect_cmd("t3_cmd_log", 16'h2200);
    no_read = 1'b0;

    // FIFO fill: one write in flight, then 5 back-to-back requests
    busy_cycles = 40; rd_delay = 2;
    push_req(1'b1, 7'h01, 8'h11, acc, held);
    wait_cmd_vld("t4", n);
    busy_cycles = 3;
    check("t4_rdy_before", req_rdy, 1);
    push_req(1'b0, 7'h10, 8'h00, acc, held);
    push_req(1'b1, 7'h11, 8'h22, acc, held);
    push_req(1'b0, 7'h12, 8'h00, acc, held);
    push_req(1'b1, 7'h13, 8'h44, acc, held);
    check("t4_full", req_rdy, 0);
    push_req(1'b0, 7'h14, 8'h00, acc, held);
    check("t4_fifth_accepted", acc, 1);
    check("t4_fifth_held", held > 30, 1);
    wait_rsp_count("t4", 6);
    expect_rsp("t4_rsp0", 9'h000);
    expect_rsp("t4_rsp1", 9'h061);
    expect_rsp("t4_rsp2", 9'h000);
    expect_rsp("t4_rsp3", 9'h062);
    expect_rsp("t4_rsp4", 9'h000);
    expect_rsp("t4_rsp5", 9'h063);
    expect_cmd("t4_cmd0", 16'h8111);
    expect_cmd("t4_cmd1", 16'h1000);
    expect_cmd("t4_cmd2", 16'h9122);
    expect_cmd("t4_cmd3", 16'h1200);
    expect_cmd("t4_cmd4", 16'h9344);
    expect_cmd("t4_cmd5", 16'h1400);

    // Backpressure on a read response
    rsp_rdy = 1'b0;
    push_req(1'b0, 7'h33, 8'h00, acc, held);
    push_req(1'b1, 7'h34, 8'h55, acc, held);
    wait_rsp_vld("t5", n);
    c0 = cmd_count;
    stable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (!(rsp_vld === 1'b1 && rsp_rdata === 8'hC7 && rsp_err === 1'b0)) stable = 1'b0;
      step();
    end
    check("t5_hold_stable", stable, 1);
    check("t5_no_new_cmd", cmd_count, c0);
    rsp_rdy = 1'b1;
    wait_cmd_vld("t5", n);
    check("t5_next_cmd_out", cmd_out, 16'hB455);
    wait_rsp_count("t5", 2);
    expect_rsp("t5_rsp0", 9'h0C7);
    expect_rsp("t5_rsp1", 9'h000);
    cmd_log.delete();

    // Reset while in WAIT_RD with two requests queued
    no_read = 1'b1; busy_cycles = 3;
    push_req(1'b0, 7'h40, 8'h00, acc, held);
    push_req(1'b1, 7'h41, 8'h01, acc, held);
    push_req(1'b1, 7'h42, 8'h02, acc, held);
    wait_cmd_rdy("t6", n);
    step(); step();
    check("t6_cmd_before_rst", cmd_out, 16'h4000);
    rst = 1'b1;
    #1;
    check("t6_outs_in_rst", {rsp_vld, cmd_vld, req_rdy, rsp_err, rsp_rdata, cmd_out}, 28'h2000000);
    step(); step();
    rst = 1'b0;
    c0 = cmd_count;
    for (int i = 0; i < 40; i++) step();
    check("t6_no_cmd_after", cmd_count, c0);
    check("t6_no_rsp_after", rsp_q.size(), 0);
    check("t6_idle_outs", {rsp_vld, cmd_vld, req_rdy}, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
